// File: rtl/eda_local_max_scan_pkg.sv
// Shared types for the local-maximum scanner: FSM states, window slice indices
// and the neighbour-mask to window-slot mapping.
package eda_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  localparam int unsigned WINDOW_WIDTH = 9;
  localparam int unsigned MASK_WIDTH   = 8;

  localparam int unsigned UPLEFT    = 8;
  localparam int unsigned UP        = 7;
  localparam int unsigned UPRIGHT   = 6;
  localparam int unsigned LEFT      = 5;
  localparam int unsigned CENTER    = 4;
  localparam int unsigned RIGHT     = 3;
  localparam int unsigned DOWNLEFT  = 2;
  localparam int unsigned DOWN      = 1;
  localparam int unsigned DOWNRIGHT = 0;

  // Widen the 8-bit neighbour mask to window slots; the centre never compares against itself.
  function automatic logic [WINDOW_WIDTH-1:0] mask_to_window(input logic [MASK_WIDTH-1:0] m);
    logic [WINDOW_WIDTH-1:0] w;
    w[UPLEFT]    = m[7];
    w[UP]        = m[6];
    w[UPRIGHT]   = m[5];
    w[LEFT]      = m[4];
    w[CENTER]    = 1'b0;
    w[RIGHT]     = m[3];
    w[DOWNLEFT]  = m[2];
    w[DOWN]      = m[1];
    w[DOWNRIGHT] = m[0];
    return w;
  endfunction

endpackage

// File: rtl/eda_local_max_scan_win_cmp.sv
// Combinational 3x3 window classifier: centre >= all valid neighbours, plus optional
// plateau detection when EDA_LMS_PLATEAU_EN is defined.
module eda_win_cmp
  import eda_pkg::*;
#(
  parameter int unsigned PIXEL_WIDTH = 8
) (
  input  logic [PIXEL_WIDTH*WINDOW_WIDTH-1:0] window_values,
  input  logic [MASK_WIDTH-1:0]               neigh_addr_valid,
  output logic                                is_max,
  output logic                                is_plateau
);

  logic [WINDOW_WIDTH-1:0] sel;
  logic [PIXEL_WIDTH-1:0]  center;

  assign sel    = mask_to_window(neigh_addr_valid);
  assign center = window_values[CENTER*PIXEL_WIDTH +: PIXEL_WIDTH];

  always_comb begin
    is_max = 1'b1;
    for (int unsigned k = 0; k < WINDOW_WIDTH; k++) begin
      if (sel[k] && (window_values[k*PIXEL_WIDTH +: PIXEL_WIDTH] > center)) begin
        is_max = 1'b0;
      end
    end
  end

`ifdef EDA_LMS_PLATEAU_EN
  logic any_eq;

  always_comb begin
    any_eq = 1'b0;
    for (int unsigned k = 0; k < WINDOW_WIDTH; k++) begin
      if (sel[k] && (window_values[k*PIXEL_WIDTH +: PIXEL_WIDTH] == center)) begin
        any_eq = 1'b1;
      end
    end
  end

  assign is_plateau = is_max && any_eq;
`else
  assign is_plateau = 1'b0;
`endif

endmodule

// File: rtl/eda_local_max_scan.sv
// Raster scanner over the image RAM emitting one local-maximum record per pixel on a
// valid/ready stream. Optional plateau output enabled by EDA_LMS_PLATEAU_EN.
module eda_local_max_scan
  import eda_pkg::*;
#(
  parameter int unsigned M           = 16,
  parameter int unsigned N           = 16,
  parameter int unsigned PIXEL_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH  = $clog2(M*N)
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic                                start,
  output logic                                busy,
  output logic                                done,
  output logic [ADDR_WIDTH-1:0]               center_addr,
  input  logic [PIXEL_WIDTH*WINDOW_WIDTH-1:0] window_values,
  input  logic [MASK_WIDTH-1:0]               neigh_addr_valid,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [ADDR_WIDTH-1:0]               out_addr,
  output logic [PIXEL_WIDTH-1:0]              out_pixel,
  output logic                                out_max,
  output logic                                out_plateau,
  output logic [ADDR_WIDTH:0]                 max_count
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(M*N - 1);

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    out_valid_q, out_valid_d;
  logic [ADDR_WIDTH-1:0]   out_addr_q, out_addr_d;
  logic [PIXEL_WIDTH-1:0]  out_pixel_q, out_pixel_d;
  logic                    out_max_q, out_max_d;
  logic                    out_plateau_q, out_plateau_d;
  logic [ADDR_WIDTH:0]     max_count_q, max_count_d;

  logic                    is_max_c;
  logic                    is_plateau_c;
  logic                    hs_c;
  logic                    adv_c;

  eda_win_cmp #(
    .PIXEL_WIDTH (PIXEL_WIDTH)
  ) u_win_cmp (
    .window_values    (window_values),
    .neigh_addr_valid (neigh_addr_valid),
    .is_max           (is_max_c),
    .is_plateau       (is_plateau_c)
  );

  assign hs_c  = out_valid_q && out_ready;
  assign adv_c = !out_valid_q || out_ready;

  // Next-state, address walk and record capture.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    done_d        = 1'b0;
    out_valid_d   = out_valid_q;
    out_addr_d    = out_addr_q;
    out_pixel_d   = out_pixel_q;
    out_max_d     = out_max_q;
    out_plateau_d = out_plateau_q;
    max_count_d   = max_count_q;

    if (hs_c && out_max_q) begin
      max_count_d = max_count_q + 1'b1;
    end

    unique case (state_q)
      ST_IDLE: begin
        addr_d = '0;
        if (start) begin
          state_d     = ST_SCAN;
          max_count_d = '0;
        end
      end
      ST_SCAN: begin
        if (adv_c) begin
          out_valid_d   = 1'b1;
          out_addr_d    = addr_q;
          out_pixel_d   = window_values[CENTER*PIXEL_WIDTH +: PIXEL_WIDTH];
          out_max_d     = is_max_c;
          out_plateau_d = is_plateau_c;
          if (addr_q == LAST_ADDR) begin
            state_d = ST_FLUSH;
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
      end
      ST_FLUSH: begin
        if (hs_c) begin
          out_valid_d = 1'b0;
          done_d      = 1'b1;
          state_d     = ST_IDLE;
          addr_d      = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      addr_q        <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      out_valid_q   <= 1'b0;
      out_addr_q    <= '0;
      out_pixel_q   <= '0;
      out_max_q     <= 1'b0;
      out_plateau_q <= 1'b0;
      max_count_q   <= '0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      out_valid_q   <= out_valid_d;
      out_addr_q    <= out_addr_d;
      out_pixel_q   <= out_pixel_d;
      out_max_q     <= out_max_d;
      out_plateau_q <= out_plateau_d;
      max_count_q   <= max_count_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign center_addr = addr_q;
  assign out_valid   = out_valid_q;
  assign out_addr    = out_addr_q;
  assign out_pixel   = out_pixel_q;
  assign out_max     = out_max_q;
  assign out_plateau = out_plateau_q;
  assign max_count   = max_count_q;

endmodule

// File: tb/tb_eda_local_max_scan.sv
// Directed bench for eda_local_max_scan on a 16x16 frame with a behavioural image RAM.
// Plateau expectations follow EDA_LMS_PLATEAU_EN.
module tb_eda_local_max_scan;

`ifdef EDA_LMS_PLATEAU_EN
  localparam bit PEN = 1'b1;
`else
  localparam bit PEN = 1'b0;
`endif

  logic        clk;
  logic        reset_n;
  logic        start;
  logic        busy;
  logic        done;
  logic [7:0]  center_addr;
  logic [71:0] win;
  logic [7:0]  mask;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_addr;
  logic [7:0]  out_pixel;
  logic        out_max;
  logic        out_plateau;
  logic [8:0]  max_count;

  logic [7:0]  img [256];
  logic [7:0]  fill;

  int vectors;
  int miscompares;

  eda_local_max_scan dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .start            (start),
    .busy             (busy),
    .done             (done),
    .center_addr      (center_addr),
    .window_values    (win),
    .neigh_addr_valid (mask),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_addr         (out_addr),
    .out_pixel        (out_pixel),
    .out_max          (out_max),
    .out_plateau      (out_plateau),
    .max_count        (max_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Image RAM: combinational window read; out-of-frame slots read 'fill' to expose masking.
  always_comb begin
    int r, c, k;
    r = 0; c = 0; k = 0;
    win  = '0;
    mask = '0;
    for (int di = -1; di <= 1; di++) begin
      for (int dj = -1; dj <= 1; dj++) begin
        r = int'(center_addr[7:4]) + di;
        c = int'(center_addr[3:0]) + dj;
        k = 8 - ((di + 1) * 3 + (dj + 1));
        if (k == 4) begin
          win[k*8 +: 8] = img[center_addr];
        end else if (r >= 0 && r < 16 && c >= 0 && c < 16) begin
          win[k*8 +: 8] = img[r*16 + c];
          mask[(k > 4) ? k - 1 : k] = 1'b1;
        end else begin
          win[k*8 +: 8] = fill;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_image(input int tst);
    for (int a = 0; a < 256; a++) begin
      case (tst)
        2:       img[a] = (a == 'h57) ? 8'd200 : 8'd10;
        3:       img[a] = (a == 0) ? 8'd50 : (a == 1) ? 8'd60 : 8'd0;
        default: img[a] = 8'd77;
      endcase
    end
    fill = (tst == 2) ? 8'd255 : (tst == 3) ? 8'd60 : 8'd0;
  endtask

  function automatic bit exp_max(input int tst, input int a);
    int r, c;
    r = a / 16;
    c = a % 16;
    case (tst)
      2:       return !(r >= 4 && r <= 6 && c >= 6 && c <= 8 && a != 'h57);
      3:       return !(a == 0 || a == 2 || a == 16 || a == 17 || a == 18);
      default: return 1'b1;
    endcase
  endfunction

  function automatic bit exp_plat(input int tst, input int a);
    case (tst)
      2:       return PEN && exp_max(tst, a) && (a != 'h57);
      3:       return PEN && exp_max(tst, a) && (a != 1);
      default: return PEN;
    endcase
  endfunction

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_center", center_addr, 0);
    chk("start_valid", out_valid, 0);
  endtask

  task automatic run_scan(input int tst, input int exp_cnt, input bit do_stall);
    int nrec;
    int cyc;
    int stall;
    bit stalled;
    bit seen_done;
    logic [7:0] sa, sp, sc;
    nrec = 0; cyc = 0; stall = 0; stalled = 0; seen_done = 0;
    sa = '0; sp = '0; sc = '0;
    set_image(tst);
    out_ready = 1'b1;
    pulse_start();
    while (!seen_done && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        seen_done = 1'b1;
        chk("done_busy", busy, 0);
        chk("done_valid", out_valid, 0);
      end else begin
        if (stall > 0) begin
          chk("stall_addr", out_addr, sa);
          chk("stall_pixel", out_pixel, sp);
          chk("stall_center", center_addr, sc);
          chk("stall_valid", out_valid, 1);
          stall--;
        end else if (do_stall && !stalled && out_valid && out_addr == 8'd3) begin
          stalled = 1'b1;
          stall = 5;
          sa = out_addr; sp = out_pixel; sc = center_addr;
        end
        out_ready = (stall == 0);
        if (out_ready && out_valid) begin
          chk("rec_addr", out_addr, nrec);
          chk("rec_pixel", out_pixel, img[nrec]);
          chk("rec_max", out_max, exp_max(tst, nrec));
          chk("rec_plateau", out_plateau, exp_plat(tst, nrec));
          nrec++;
        end
      end
    end
    chk("scan_done_seen", seen_done, 1);
    chk("scan_records", nrec, 256);
    chk("scan_max_count", max_count, exp_cnt);
    if (do_stall) chk("stall_seen", stalled, 1);
    @(negedge clk);
    chk("done_single", done, 0);
    chk("max_count_hold", max_count, exp_cnt);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_center"}, center_addr, 0);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_addr"}, out_addr, 0);
    chk({tag, "_pixel"}, out_pixel, 0);
    chk({tag, "_max"}, out_max, 0);
    chk({tag, "_plateau"}, out_plateau, 0);
    chk({tag, "_count"}, max_count, 0);
  endtask

  initial begin
    int cnt;
    bit hit;
    vectors = 0;
    miscompares = 0;
    reset_n = 1'b0;
    start = 1'b0;
    out_ready = 1'b1;
    set_image(1);
    repeat (3) @(negedge clk);
    chk_reset_values("rst");
    reset_n = 1'b1;
    @(negedge clk);

    // Constant image: every pixel is a (plateau) maximum.
    run_scan(1, 256, 1'b0);
    // Single peak at 0x57: its 8 neighbours are not maxima.
    run_scan(2, 248, 1'b0);
    // Corner pair with back-pressure at address 3.
    run_scan(3, 251, 1'b1);

    // Mid-scan start is ignored; reset at address 100 aborts without done.
    set_image(1);
    out_ready = 1'b1;
    pulse_start();
    cnt = 0;
    hit = 1'b0;
    for (int cyc = 0; cyc < 400 && !hit; cyc++) begin
      @(negedge clk);
      start = (cyc == 30);
      if (cyc == 31) chk("t5_busy_after_start", busy, 1);
      if (out_valid) begin
        chk("t5_order", out_addr, cnt);
        cnt++;
        if (out_addr == 8'd100) hit = 1'b1;
      end
    end
    start = 1'b0;
    chk("t5_reached_100", hit, 1);
    chk("t5_count_before_reset", max_count, 100);
    reset_n = 1'b0;
    #1;
    chk_reset_values("midrst");
    @(negedge clk);
    reset_n = 1'b1;
    hit = 1'b0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      if (done || busy || out_valid) hit = 1'b1;
    end
    chk("t5_quiet_after_reset", hit, 0);
    run_scan(1, 256, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
